// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Write-side tracker for the general register file, placed in the decode
//   stage. For every GPR it keeps a Tnew countdown (cycles until the pending
//   result can be forwarded) and a count of outstanding writes. It stalls
//   decode while a source operand is needed before its producer can forward
//   it. It also tells the forwarding muxes when a register has a pending
//   write that is newer than the register file contents.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   flush               drop all tracking state (sb_err is kept)
//   issue_valid/_rd/_tnew  D-stage instruction and its destination/Tnew
//   srcN_addr/_tuse     D-stage source operands and their Tuse (N = 1, 2)
//   wb_we, wb_addr      register-file write from the W stage
//   stall               combinational hazard stall
//   issue_acc           issue_valid & ~stall
//   srcN_busy           source has at least one outstanding write
//   sb_err              sticky in-flight counter overflow/underflow
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 3,
  parameter int INF_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [CNT_W-1:0] issue_tnew,
  input  logic [4:0]       src1_addr,
  input  logic [1:0]       src1_tuse,
  input  logic [4:0]       src2_addr,
  input  logic [1:0]       src2_tuse,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  output logic             stall,
  output logic             issue_acc,
  output logic             src1_busy,
  output logic             src2_busy,
  output logic             sb_err
);

  localparam logic [INF_W-1:0] INF_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [INF_W-1:0] inf_q [NREG];
  logic [INF_W-1:0] inf_d [NREG];
  logic             sb_err_q;
  logic             sb_err_d;

  logic [CNT_W-1:0] src1_cnt;
  logic [CNT_W-1:0] src2_cnt;
  logic [INF_W-1:0] src1_inf;
  logic [INF_W-1:0] src2_inf;

  // r0 is never tracked, so a zero address reads as idle.
  always_comb begin
    src1_cnt = '0;
    src2_cnt = '0;
    src1_inf = '0;
    src2_inf = '0;
    if (src1_addr != 5'd0) begin
      src1_cnt = cnt_q[src1_addr];
      src1_inf = inf_q[src1_addr];
    end
    if (src2_addr != 5'd0) begin
      src2_cnt = cnt_q[src2_addr];
      src2_inf = inf_q[src2_addr];
    end
  end

  // Stall does not look at issue_valid; issue_acc is the gated version.
  assign stall     = (src1_cnt > CNT_W'(src1_tuse)) || (src2_cnt > CNT_W'(src2_tuse));
  assign issue_acc = issue_valid && !stall;
  assign src1_busy = (src1_inf != '0);
  assign src2_busy = (src2_inf != '0);
  assign sb_err    = sb_err_q;

  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = '0;
      inf_d[r] = '0;
      // Flush leaves every entry cleared and ignores same-cycle issue/wb.
      if (r != 0 && !flush) begin
        // A freshly accepted issue reloads the countdown instead of decrementing.
        if (issue_acc && issue_rd == 5'(r))
          cnt_d[r] = issue_tnew;
        else if (cnt_q[r] != '0)
          cnt_d[r] = cnt_q[r] - CNT_W'(1);

        inf_d[r] = inf_q[r];
        // Issue and write-back to the same register cancel out.
        case ({issue_acc && issue_rd == 5'(r), wb_we && wb_addr == 5'(r)})
          2'b10: begin
            if (inf_q[r] == INF_MAX) sb_err_d = 1'b1;
            else                     inf_d[r] = inf_q[r] + INF_W'(1);
          end
          2'b01: begin
            if (inf_q[r] == '0) sb_err_d = 1'b1;
            else                inf_d[r] = inf_q[r] - INF_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
        inf_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      inf_q    <= inf_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [2:0] issue_tnew;
  logic [4:0] src1_addr;
  logic [1:0] src1_tuse;
  logic [4:0] src2_addr;
  logic [1:0] src2_tuse;
  logic       wb_we;
  logic [4:0] wb_addr;
  logic       stall;
  logic       issue_acc;
  logic       src1_busy;
  logic       src2_busy;
  logic       sb_err;

  reg_scoreboard #(.NREG(32), .CNT_W(3), .INF_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tnew(issue_tnew),
    .src1_addr(src1_addr), .src1_tuse(src1_tuse),
    .src2_addr(src2_addr), .src2_tuse(src2_tuse),
    .wb_we(wb_we), .wb_addr(wb_addr),
    .stall(stall), .issue_acc(issue_acc),
    .src1_busy(src1_busy), .src2_busy(src2_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  stall;
    logic  acc;
    logic  b1;
    logic  b2;
    logic  err;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are valid every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "stall",     stall,     e.stall);
      cmp(e.name, "issue_acc", issue_acc, e.acc);
      cmp(e.name, "src1_busy", src1_busy, e.b1);
      cmp(e.name, "src2_busy", src2_busy, e.b2);
      cmp(e.name, "sb_err",    sb_err,    e.err);
    end
  end

  task automatic cmp(input string name, input string field, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %b expected %b", name, field, act, req);
    end
  endtask

  // Start a new cycle just after the edge with all inputs idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    reset       = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    issue_tnew  = 3'd0;
    src1_addr   = 5'd0;
    src1_tuse   = 2'd3;
    src2_addr   = 5'd0;
    src2_tuse   = 2'd3;
    wb_we       = 1'b0;
    wb_addr     = 5'd0;
  endtask

  task automatic iss(input logic [4:0] rd, input logic [2:0] tnew);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_tnew  = tnew;
  endtask

  task automatic s1(input logic [4:0] a, input logic [1:0] t);
    src1_addr = a;
    src1_tuse = t;
  endtask

  task automatic s2(input logic [4:0] a, input logic [1:0] t);
    src2_addr = a;
    src2_tuse = t;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_we   = 1'b1;
    wb_addr = a;
  endtask

  task automatic expect_out(input logic st, input logic acc, input logic b1,
                            input logic b2, input logic err, input string name);
    exp_t e;
    e.stall = st; e.acc = acc; e.b1 = b1; e.b2 = b2; e.err = err; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0; issue_tnew = 3'd0;
    src1_addr = 5'd0; src1_tuse = 2'd3; src2_addr = 5'd0; src2_tuse = 2'd3;
    wb_we = 1'b0; wb_addr = 5'd0;
    repeat (2) @(posedge clk);

    // Reset state
    cyc(); s1(5'd8, 2'd0); s2(5'd9, 2'd0);
    expect_out(0, 0, 0, 0, 0, "reset_state");

    // lw-use hazard on r8
    cyc(); iss(5'd8, 3'd2);
    expect_out(0, 1, 0, 0, 0, "lw_issue");
    cyc(); iss(5'd0, 3'd0); s1(5'd8, 2'd1);
    expect_out(1, 0, 1, 0, 0, "lw_use_stall");
    cyc(); iss(5'd0, 3'd0); s1(5'd8, 2'd1);
    expect_out(0, 1, 1, 0, 0, "lw_use_release");
    cyc(); wb(5'd8); s1(5'd8, 2'd3);
    expect_out(0, 0, 1, 0, 0, "lw_wb_cycle");

    // ALU -> ALU on r9; also confirms r8 is no longer busy
    cyc(); iss(5'd9, 3'd1); s1(5'd8, 2'd0);
    expect_out(0, 1, 0, 0, 0, "alu_issue");
    cyc(); iss(5'd0, 3'd0); s1(5'd9, 2'd0);
    expect_out(1, 0, 1, 0, 0, "alu_stall");
    cyc(); iss(5'd0, 3'd0); s1(5'd9, 2'd0); wb(5'd9);
    expect_out(0, 1, 1, 0, 0, "alu_release");

    // r0 immunity
    cyc(); iss(5'd0, 3'd3); s2(5'd9, 2'd3);
    expect_out(0, 1, 0, 0, 0, "r0_issue");
    cyc(); s1(5'd0, 2'd0); s2(5'd0, 2'd0);
    expect_out(0, 0, 0, 0, 0, "r0_use");

    // Same-cycle issue + wb on r5
    cyc(); iss(5'd5, 3'd2);
    expect_out(0, 1, 0, 0, 0, "same_setup");
    cyc(); iss(5'd5, 3'd3); wb(5'd5); s1(5'd5, 2'd3);
    expect_out(0, 1, 1, 0, 0, "same_issue_wb");
    cyc(); s1(5'd5, 2'd2);
    expect_out(1, 0, 1, 0, 0, "same_cnt_loaded");
    cyc(); wb(5'd5); s1(5'd5, 2'd2);
    expect_out(0, 0, 1, 0, 0, "same_final_wb");
    cyc(); s1(5'd5, 2'd0);
    expect_out(1, 0, 0, 0, 0, "same_inf_zero");

    // Flush mid-operation; flush beats a same-cycle issue and an underflowing wb
    cyc(); iss(5'd3, 3'd3);
    expect_out(0, 1, 0, 0, 0, "flush_issue");
    cyc(); flush = 1'b1; iss(5'd4, 3'd5); wb(5'd5);
    expect_out(0, 1, 0, 0, 0, "flush_cycle");
    cyc(); s1(5'd3, 2'd0); s2(5'd4, 2'd0);
    expect_out(0, 0, 0, 0, 0, "flush_after");

    // Overflow of r7 in-flight counter
    cyc(); iss(5'd7, 3'd0); s2(5'd7, 2'd3);
    expect_out(0, 1, 0, 0, 0, "ovf_1");
    cyc(); iss(5'd7, 3'd0); s2(5'd7, 2'd3);
    expect_out(0, 1, 0, 1, 0, "ovf_2");
    cyc(); iss(5'd7, 3'd0); s2(5'd7, 2'd3);
    expect_out(0, 1, 0, 1, 0, "ovf_3");
    cyc(); iss(5'd7, 3'd0); s2(5'd7, 2'd3);
    expect_out(0, 1, 0, 1, 0, "ovf_4");
    cyc(); flush = 1'b1; s2(5'd7, 2'd3);
    expect_out(0, 0, 0, 1, 1, "ovf_sticky");
    cyc(); s2(5'd7, 2'd3);
    expect_out(0, 0, 0, 0, 1, "ovf_after_flush");
    cyc(); reset = 1'b1; s2(5'd7, 2'd3);
    expect_out(0, 0, 0, 0, 1, "ovf_reset_cycle");
    cyc();
    expect_out(0, 0, 0, 0, 0, "ovf_cleared");

    // Underflow: write-back with nothing in flight
    cyc(); wb(5'd10);
    expect_out(0, 0, 0, 0, 0, "udf_wb");
    cyc();
    expect_out(0, 0, 0, 0, 1, "udf_err");

    cyc();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain queue_left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
